// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants, slot record and helpers for the writeback port arbiter.
// WB_NUM_REQ is the default requester count: 0 = ALU, 1 = load, 2 = mul/div.
package wb_port_arbiter_pkg;

    localparam int          WB_NUM_REQ = 3;
    localparam logic [4:0]  ZERO_REG   = 5'd0;
    localparam logic [31:0] ZERO_WORD  = 32'd0;

    // One buffered, not-yet-written register-file write
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_slot_t;

    // Pending-mask contribution of one destination; x0 never shows as pending
    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        logic [31:0] m;
        m = 32'd1 << rd;
        if (rd == ZERO_REG) begin
            m = ZERO_WORD;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first valid slot
// found scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
module wb_rr_picker
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 2) ? 2 : 1
) (
    input  logic [NUM_REQ-1:0] slot_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [PTR_W-1:0] scan_idx;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] ptr, input int k);
        int sum;
        sum = (int'(ptr) + k) % NUM_REQ;
        return PTR_W'(sum);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = wrap_idx(rr_ptr, k);
            if (!grant_any && slot_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
                grant_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between writeback sources,
// each buffered in a one-entry slot and drained round-robin, one per cycle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [5*NUM_REQ-1:0]    req_rd,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic                    RegWrite,
    output logic [4:0]              Rd,
    output logic [31:0]             Wr_data,
    output logic [31:0]             pending_mask
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    wb_slot_t             slot_q [NUM_REQ];
    logic [NUM_REQ-1:0]   slot_valid;
    logic [PTR_W-1:0]     rr_ptr;

    logic [NUM_REQ-1:0]   grant_raw;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any_raw;
    logic [NUM_REQ-1:0]   grant;
    logic                 grant_any;
    logic [NUM_REQ-1:0]   accept;

    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_valid[i] = slot_q[i].valid;
        end
    end

    wb_rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .PTR_W     (PTR_W)
    ) u_picker (
        .slot_valid(slot_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant_raw),
        .grant_idx (grant_idx),
        .grant_any (grant_any_raw)
    );

    // Reset suppresses the write port so buffered entries never reach the register file
    always_comb begin
        grant     = rst ? '0 : grant_raw;
        grant_any = !rst && grant_any_raw;
    end

    always_comb begin
        req_ready = '0;
        accept    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && (!slot_valid[i] || grant[i]);
            accept[i]    = req_valid[i] && req_ready[i];
        end
    end

    // An accepted x0 write is dropped; it still frees the slot if that slot drains
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i] && (req_rd[5*i +: 5] != ZERO_REG)) begin
                    slot_q[i].valid <= 1'b1;
                    slot_q[i].rd    <= req_rd[5*i +: 5];
                    slot_q[i].data  <= req_data[32*i +: 32];
                end else if (accept[i] || grant[i]) begin
                    slot_q[i].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Write port is driven purely from slot state, never from req_*
    always_comb begin
        RegWrite = grant_any;
        Rd       = ZERO_REG;
        Wr_data  = ZERO_WORD;
        if (grant_any) begin
            Rd      = slot_q[grant_idx].rd;
            Wr_data = slot_q[grant_idx].data;
        end
    end

    always_comb begin
        pending_mask = ZERO_WORD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (slot_q[i].valid) begin
                pending_mask = pending_mask | rd_onehot(slot_q[i].rd);
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// as stimulus is issued and a negedge monitor pops and compares them.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [5*N-1:0]    req_rd = '0;
    logic [32*N-1:0]   req_data = '0;
    logic              RegWrite;
    logic [4:0]        Rd;
    logic [31:0]       Wr_data;
    logic [31:0]       pending_mask;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    wb_port_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .RegWrite    (RegWrite),
        .Rd          (Rd),
        .Wr_data     (Wr_data),
        .pending_mask(pending_mask)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver / checking helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        req_valid[i]        = v;
        req_rd[5*i +: 5]    = rd;
        req_data[32*i +: 32] = d;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [36:0] e;
        if (RegWrite) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", Rd, Wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wb_write", {27'd0, Rd, Wr_data}, {27'd0, e});
            end
        end else begin
            check("idle_outputs", {27'd0, Rd, Wr_data}, 64'd0);
        end
    end

    initial begin
        int na;
        int nb;
        logic [N-1:0] rdy;
        logic [N-1:0] v;

        // Reset then idle
        step();
        step();
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(req_ready), 64'h7);
        check("idle_regwrite", 64'(RegWrite), 64'd0);
        check("idle_pending", 64'(pending_mask), 64'd0);

        // All three in one cycle from rr_ptr = 0: x1, x2, x3 in order
        step();
        set_req(0, 1'b1, 5'd1, 32'h1111_0001);
        set_req(1, 1'b1, 5'd2, 32'h2222_0002);
        set_req(2, 1'b1, 5'd3, 32'h3333_0003);
        push_exp(5'd1, 32'h1111_0001);
        push_exp(5'd2, 32'h2222_0002);
        push_exp(5'd3, 32'h3333_0003);
        step();
        req_valid = '0;
        @(negedge clk);
        check("all3_pending_c1", 64'(pending_mask), 64'hE);
        check("all3_ready_c1", 64'(req_ready), 64'h1);
        step();
        @(negedge clk);
        check("all3_pending_c2", 64'(pending_mask), 64'hC);
        check("all3_ready_c2", 64'(req_ready), 64'h3);
        step();
        @(negedge clk);
        check("all3_pending_c3", 64'(pending_mask), 64'h8);
        check("all3_ready_c3", 64'(req_ready), 64'h7);
        step();
        @(negedge clk);
        check("all3_pending_c4", 64'(pending_mask), 64'd0);

        // Single write from the load unit
        step();
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        push_exp(5'd5, 32'hDEAD_BEEF);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_regwrite", 64'(RegWrite), 64'd1);
        check("single_pending", 64'(pending_mask), 64'h20);
        step();
        @(negedge clk);
        check("single_pending_after", 64'(pending_mask), 64'd0);
        check("single_regwrite_after", 64'(RegWrite), 64'd0);

        // ALU and mul/div streaming from rr_ptr = 2: grants alternate 2,0,2,0...
        for (int k = 0; k < 4; k++) begin
            push_exp(5'(16 + k), 32'hB000_0000 | 32'(k));
            push_exp(5'(8 + k), 32'hA000_0000 | 32'(k));
        end
        na = 0;
        nb = 0;
        step();
        for (int cyc = 0; cyc < 40 && (na < 4 || nb < 4); cyc++) begin
            set_req(0, na < 4, 5'(8 + na), 32'hA000_0000 | 32'(na));
            set_req(2, nb < 4, 5'(16 + nb), 32'hB000_0000 | 32'(nb));
            @(negedge clk);
            rdy = req_ready;
            v   = req_valid;
            step();
            if (v[0] && rdy[0]) na++;
            if (v[2] && rdy[2]) nb++;
        end
        req_valid = '0;
        check("stream_accepts", 64'(na + nb), 64'd8);
        wait_drain("stream_drained");

        // x0 write: accepted and discarded
        step();
        set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("x0_ready", 64'(req_ready[0]), 64'd1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("x0_regwrite", 64'(RegWrite), 64'd0);
        check("x0_pending", 64'(pending_mask), 64'd0);
        step();
        @(negedge clk);
        check("x0_regwrite_later", 64'(RegWrite), 64'd0);

        // Three slots full, reset pulsed: everything is discarded
        step();
        set_req(0, 1'b1, 5'd4, 32'hC000_0004);
        set_req(1, 1'b1, 5'd5, 32'hC000_0005);
        set_req(2, 1'b1, 5'd6, 32'hC000_0006);
        step();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_pending", 64'(pending_mask), 64'h70);
        check("rstmid_regwrite", 64'(RegWrite), 64'd0);
        check("rstmid_ready", 64'(req_ready), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_pending", 64'(pending_mask), 64'd0);
        check("postrst_regwrite", 64'(RegWrite), 64'd0);
        check("postrst_ready", 64'(req_ready), 64'h7);

        // rr_ptr back at 0: order must be x7, x8, x9
        step();
        set_req(0, 1'b1, 5'd7, 32'hE000_0007);
        set_req(1, 1'b1, 5'd8, 32'hE000_0008);
        set_req(2, 1'b1, 5'd9, 32'hE000_0009);
        push_exp(5'd7, 32'hE000_0007);
        push_exp(5'd8, 32'hE000_0008);
        push_exp(5'd9, 32'hE000_0009);
        step();
        req_valid = '0;
        wait_drain("postrst_drained");

        // Final report
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
